mmio_bridge: RTL and testbench

Parametrised memory-mapped I/O bridge for the MEM stage of the pipelined core. Each MEM-stage load/store address is decoded against NUM_REGIONS peripheral windows. A hit becomes an Avalon-MM master transfer with proper waitrequest handling. A miss is steered to local data RAM.
While a peripheral transfer is outstanding the bridge drives a pipeline-wide stall. The bridge adds a timeout/error path and a registered read-data return, generalising the single hard-wired HEX/JTAG-UART decode to N regions.

---
 rtl/mmio_pkg.sv | 15 +
 rtl/mmio_decoder.sv | 42 ++++
 rtl/mmio_bridge.sv | 156 +++++++++++++++
 tb/tb_mmio_bridge.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bridge and its address decoder.
package mmio_pkg;

  // Upper bound on peripheral windows; sets the width of region indices.
  localparam int unsigned MAX_REGIONS  = 8;
  localparam int unsigned REGION_IDX_W = $clog2(MAX_REGIONS);

  // Bridge transfer state.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/mmio_decoder.sv
// Address decoder: masked compare against each peripheral window.
// When windows overlap, the lowest-indexed region wins.
module mmio_decoder
  import mmio_pkg::*;
#(
  parameter int unsigned                   ADDR_W      = 32,
  parameter int unsigned                   NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_W-1:0]       addr_i,
  output logic                    hit_any_o,
  output logic [REGION_IDX_W-1:0] hit_idx_o,
  output logic [NUM_REGIONS-1:0]  hit_onehot_o
);

  logic [NUM_REGIONS-1:0] hit;

  // Raw per-region window match.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = (addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W];
    end
  end

  // Priority encode: scan high to low so the lowest matching index is left standing.
  always_comb begin
    hit_onehot_o = '0;
    hit_idx_o    = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_onehot_o    = '0;
        hit_onehot_o[i] = 1'b1;
        hit_idx_o       = REGION_IDX_W'(i);
      end
    end
  end

  assign hit_any_o = |hit;

endmodule

// File: rtl/mmio_bridge.sv
// MEM-stage MMIO bridge: decodes loads/stores against peripheral windows, runs
// hits as Avalon-MM transfers (with waitrequest and timeout) and stalls the
// pipeline until the response pulse. Misses are flagged for local data RAM.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned                   ADDR_W         = 32,
  parameter int unsigned                   DATA_W         = 32,
  parameter int unsigned                   NUM_REGIONS    = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE    = {32'h0000_0400, 32'h0000_0300,
                                                             32'h0000_0200, 32'h0000_0100},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK    = {4{32'hFFFF_FFF0}},
  parameter int unsigned                   TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   local_sel,
  output logic                   stall,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [2:0]             rsp_region,
  output logic [NUM_REGIONS-1:0] av_chipselect,
  output logic [ADDR_W-1:0]      av_address,
  output logic                   av_read_n,
  output logic                   av_write_n,
  output logic [DATA_W-1:0]      av_writedata,
  output logic [DATA_W/8-1:0]    av_byteenable,
  input  logic [DATA_W-1:0]      av_readdata,
  input  logic                   av_waitrequest
);

  // Width 1 minimum so a disabled timeout still yields a legal counter.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [NUM_REGIONS-1:0]   av_cs_q;
  logic [ADDR_W-1:0]        av_addr_q;
  logic [DATA_W-1:0]        av_wdata_q;
  logic [DATA_W/8-1:0]      av_be_q;
  logic                     av_read_n_q;
  logic                     av_write_n_q;
  logic                     rsp_valid_q;
  logic [DATA_W-1:0]        rsp_rdata_q;
  logic                     rsp_err_q;
  logic [REGION_IDX_W-1:0]  rsp_region_q;

  logic                     hit_any;
  logic [REGION_IDX_W-1:0]  hit_idx;
  logic [NUM_REGIONS-1:0]   hit_onehot;
  logic                     timeout_hit;

  mmio_decoder #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .addr_i       (req_addr),
    .hit_any_o    (hit_any),
    .hit_idx_o    (hit_idx),
    .hit_onehot_o (hit_onehot)
  );

  // The current ACCESS cycle is the last one the slave is allowed to stall.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  // Transfer FSM with all Avalon and response outputs registered.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      av_cs_q      <= '0;
      av_addr_q    <= '0;
      av_wdata_q   <= '0;
      av_be_q      <= '0;
      av_read_n_q  <= 1'b1;
      av_write_n_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_region_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          rsp_valid_q <= 1'b0;
          if (req_valid && hit_any) begin
            state_q      <= StAccess;
            cnt_q        <= '0;
            av_cs_q      <= hit_onehot;
            av_addr_q    <= req_addr;
            av_wdata_q   <= req_wdata;
            av_be_q      <= req_be;
            av_read_n_q  <= req_write;
            av_write_n_q <= ~req_write;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_region_q <= hit_idx;
          end
        end
        StAccess: begin
          if (!av_waitrequest) begin
            // write strobe still high here means this is a load
            rsp_rdata_q  <= av_write_n_q ? av_readdata : '0;
            state_q      <= StDone;
            rsp_valid_q  <= 1'b1;
            av_cs_q      <= '0;
            av_read_n_q  <= 1'b1;
            av_write_n_q <= 1'b1;
          end else if (timeout_hit) begin
            cnt_q        <= cnt_q + CNT_W'(1);
            rsp_err_q    <= 1'b1;
            rsp_rdata_q  <= '0;
            state_q      <= StDone;
            rsp_valid_q  <= 1'b1;
            av_cs_q      <= '0;
            av_read_n_q  <= 1'b1;
            av_write_n_q <= 1'b1;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          // req_valid deliberately ignored so the same request is not re-issued
          rsp_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pipeline-facing steering and stall.
  assign local_sel = req_valid & ~hit_any & (state_q == StIdle);
  assign stall     = ((state_q == StIdle) & req_valid & hit_any) | (state_q == StAccess);

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_region    = 3'(rsp_region_q);
  assign av_chipselect = av_cs_q;
  assign av_address    = av_addr_q;
  assign av_read_n     = av_read_n_q;
  assign av_write_n    = av_write_n_q;
  assign av_writedata  = av_wdata_q;
  assign av_byteenable = av_be_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: zero-wait read, wait-state write, miss,
// timeout and recovery, reset mid-transfer, and overlapping windows.
module tb_mmio_bridge;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] av_readdata;
  logic        av_waitrequest;

  // Main instance: default windows, short timeout.
  logic        local_sel, stall, rsp_valid, rsp_err, av_read_n, av_write_n;
  logic [31:0] rsp_rdata, av_address, av_writedata;
  logic [2:0]  rsp_region;
  logic [3:0]  av_chipselect, av_byteenable;

  // Overlap instance: region 0 (0x100/0xFFFFFF00) contains region 1 (0x100/0xFFFFFFF0).
  logic        o_local_sel, o_stall, o_rsp_valid, o_rsp_err, o_av_read_n, o_av_write_n;
  logic [31:0] o_rsp_rdata, o_av_address, o_av_writedata;
  logic [2:0]  o_rsp_region;
  logic [3:0]  o_av_chipselect, o_av_byteenable;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  mmio_bridge #(
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .clock          (clock),
    .clear          (clear),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .local_sel      (local_sel),
    .stall          (stall),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .rsp_region     (rsp_region),
    .av_chipselect  (av_chipselect),
    .av_address     (av_address),
    .av_read_n      (av_read_n),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_byteenable  (av_byteenable),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest)
  );

  mmio_bridge #(
    .REGION_BASE ({32'h0000_0400, 32'h0000_0300, 32'h0000_0100, 32'h0000_0100}),
    .REGION_MASK ({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF00})
  ) u_ov (
    .clock          (clock),
    .clear          (clear),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .local_sel      (o_local_sel),
    .stall          (o_stall),
    .rsp_valid      (o_rsp_valid),
    .rsp_rdata      (o_rsp_rdata),
    .rsp_err        (o_rsp_err),
    .rsp_region     (o_rsp_region),
    .av_chipselect  (o_av_chipselect),
    .av_address     (o_av_address),
    .av_read_n      (o_av_read_n),
    .av_write_n     (o_av_write_n),
    .av_writedata   (o_av_writedata),
    .av_byteenable  (o_av_byteenable),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and checks run 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear          = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_be         = 4'hF;
    av_readdata    = '0;
    av_waitrequest = 1'b0;
    step();
    step();
    clear = 1'b0;
    #1;

    // Reset state
    chk("rst_read_n",  av_read_n, 1);
    chk("rst_write_n", av_write_n, 1);
    chk("rst_cs",      av_chipselect, 0);
    chk("rst_addr",    av_address, 0);
    chk("rst_wdata",   av_writedata, 0);
    chk("rst_be",      av_byteenable, 0);
    chk("rst_rvalid",  rsp_valid, 0);
    chk("rst_rdata",   rsp_rdata, 0);
    chk("rst_err",     rsp_err, 0);
    chk("rst_region",  rsp_region, 0);
    chk("rst_stall",   stall, 0);

    // Zero-wait read from region 1
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0204;
    av_readdata = 32'hDEAD_BEEF; av_waitrequest = 1'b0;
    #1;
    chk("zr_c0_stall",  stall, 1);
    chk("zr_c0_local",  local_sel, 0);
    chk("zr_c0_read_n", av_read_n, 1);
    step();
    chk("zr_c1_read_n", av_read_n, 0);
    chk("zr_c1_cs",     av_chipselect, 4'b0010);
    chk("zr_c1_addr",   av_address, 32'h0000_0204);
    chk("zr_c1_stall",  stall, 1);
    chk("zr_c1_rvalid", rsp_valid, 0);
    step();
    chk("zr_c2_rvalid", rsp_valid, 1);
    chk("zr_c2_rdata",  rsp_rdata, 32'hDEAD_BEEF);
    chk("zr_c2_region", rsp_region, 1);
    chk("zr_c2_err",    rsp_err, 0);
    chk("zr_c2_stall",  stall, 0);
    chk("zr_c2_read_n", av_read_n, 1);
    chk("zr_c2_local",  local_sel, 0);
    req_valid = 1'b0;
    step();
    chk("zr_c3_rvalid", rsp_valid, 0);

    // Store with three wait states to region 0
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0108;
    req_wdata = 32'h1234_5678; req_be = 4'b0110;
    av_readdata = 32'hFFFF_FFFF; av_waitrequest = 1'b1;
    #1;
    chk("wr_c0_stall", stall, 1);
    step();
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("wr_c%0d_write_n", c), av_write_n, 0);
      chk($sformatf("wr_c%0d_read_n", c),  av_read_n, 1);
      chk($sformatf("wr_c%0d_addr", c),    av_address, 32'h0000_0108);
      chk($sformatf("wr_c%0d_wdata", c),   av_writedata, 32'h1234_5678);
      chk($sformatf("wr_c%0d_be", c),      av_byteenable, 4'b0110);
      chk($sformatf("wr_c%0d_stall", c),   stall, 1);
      step();
    end
    av_waitrequest = 1'b0;
    #1;
    chk("wr_c4_write_n", av_write_n, 0);
    chk("wr_c4_cs",      av_chipselect, 4'b0001);
    chk("wr_c4_rvalid",  rsp_valid, 0);
    step();
    chk("wr_c5_rvalid",  rsp_valid, 1);
    chk("wr_c5_rdata",   rsp_rdata, 0);
    chk("wr_c5_region",  rsp_region, 0);
    chk("wr_c5_write_n", av_write_n, 1);
    req_valid = 1'b0; req_write = 1'b0; req_be = 4'hF;
    step();

    // Miss goes to local RAM
    req_valid = 1'b1; req_addr = 32'h0000_0040;
    #1;
    chk("miss_local", local_sel, 1);
    chk("miss_stall", stall, 0);
    step();
    chk("miss_read_n", av_read_n, 1);
    chk("miss_cs",     av_chipselect, 0);
    chk("miss_rvalid", rsp_valid, 0);
    req_valid = 1'b0;
    step();
    chk("miss_rvalid2", rsp_valid, 0);

    // Timeout with waitrequest stuck high (limit 4)
    req_valid = 1'b1; req_addr = 32'h0000_0304;
    av_readdata = 32'hAAAA_5555; av_waitrequest = 1'b1;
    step();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_c%0d_read_n", c), av_read_n, 0);
      chk($sformatf("to_c%0d_rvalid", c), rsp_valid, 0);
      step();
    end
    chk("to_c5_rvalid", rsp_valid, 1);
    chk("to_c5_err",    rsp_err, 1);
    chk("to_c5_rdata",  rsp_rdata, 0);
    chk("to_c5_region", rsp_region, 2);
    chk("to_c5_read_n", av_read_n, 1);
    chk("to_c5_cs",     av_chipselect, 0);
    chk("to_c5_stall",  stall, 0);
    req_valid = 1'b0;
    step();
    chk("to_c6_rvalid", rsp_valid, 0);
    chk("to_c6_stall",  stall, 0);

    // Follow-up request succeeds and clears the error
    req_valid = 1'b1; req_addr = 32'h0000_0404;
    av_readdata = 32'hCAFE_F00D; av_waitrequest = 1'b0;
    step();
    chk("rec_cs",     av_chipselect, 4'b1000);
    chk("rec_err_c1", rsp_err, 0);
    step();
    chk("rec_rvalid", rsp_valid, 1);
    chk("rec_err",    rsp_err, 0);
    chk("rec_rdata",  rsp_rdata, 32'hCAFE_F00D);
    chk("rec_region", rsp_region, 3);
    req_valid = 1'b0;
    step();

    // Reset during a stalled access
    req_valid = 1'b1; req_addr = 32'h0000_0200; av_waitrequest = 1'b1;
    step();
    chk("rma_read_n_c1", av_read_n, 0);
    step();
    chk("rma_read_n_c2", av_read_n, 0);
    clear = 1'b1;
    step();
    clear = 1'b0; req_valid = 1'b0;
    #1;
    chk("rma_read_n", av_read_n, 1);
    chk("rma_write_n", av_write_n, 1);
    chk("rma_cs",     av_chipselect, 0);
    chk("rma_stall",  stall, 0);
    chk("rma_rvalid", rsp_valid, 0);
    step();
    chk("rma_rvalid2", rsp_valid, 0);

    // Overlapping windows: lowest index wins
    av_waitrequest = 1'b0; av_readdata = 32'h0BAD_F00D;
    req_valid = 1'b1; req_addr = 32'h0000_0104;
    #1;
    chk("ov_c0_stall", o_stall, 1);
    step();
    chk("ov_c1_cs",     o_av_chipselect, 4'b0001);
    chk("ov_c1_read_n", o_av_read_n, 0);
    step();
    chk("ov_c2_rvalid", o_rsp_valid, 1);
    chk("ov_c2_region", o_rsp_region, 0);
    chk("ov_c2_rdata",  o_rsp_rdata, 32'h0BAD_F00D);
    req_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
